arcade_input_cond: RTL and testbench



---
 rtl/arcade_input_cond.sv | 217 +++++++++++++++++++++
 tb/tb_arcade_input_cond.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_cond.sv
// arcade_input_cond
//   Player-input conditioner between hps_io joystick words and an arcade
//   core. Per-player or shared (OR-merged) routing, masked autofire on a
//   single shared timebase, coin bit stripped from the joystick words, and a
//   per-player coin pulse shaper with a saturating 2-bit credit queue.
//
//   Optional feature: define ARCADE_INPUT_SOCD_EN to clear opposing
//   direction pairs (R+L, U+D) after autofire. Undefined: directions pass
//   through unmodified. Latency is identical in both builds.
//
// Ports
//   clk_sys   in  1            system clock
//   reset     in  1            synchronous, active-high reset
//   joy_in    in  NPLAYERS*JW  raw joystick words, player p at [p*JW +: JW]
//   share     in  1            1: every player gets OR of all processed words
//   af_en     in  1            autofire enable
//   af_mask   in  JW           bits subject to autofire
//   joy_out   out NPLAYERS*JW  conditioned words (coin bit always 0)
//   coin_out  out NPLAYERS     shaped coin pulse per player
//   coin_busy out NPLAYERS     player FSM not idle or credits queued
module arcade_input_cond #(
  parameter int NPLAYERS   = 2,
  parameter int JW         = 16,
  parameter int COIN_BIT   = 8,
  parameter int COIN_PULSE = 50000,
  parameter int COIN_GAP   = 30000,
  parameter int AF_PERIOD  = 1000000
) (
  input  logic                   clk_sys,
  input  logic                   reset,
  input  logic [NPLAYERS*JW-1:0] joy_in,
  input  logic                   share,
  input  logic                   af_en,
  input  logic [JW-1:0]          af_mask,
  output logic [NPLAYERS*JW-1:0] joy_out,
  output logic [NPLAYERS-1:0]    coin_out,
  output logic [NPLAYERS-1:0]    coin_busy
);

  localparam int AFW = (AF_PERIOD  > 1) ? $clog2(AF_PERIOD)  : 1;
  localparam int CPW = (COIN_PULSE > 1) ? $clog2(COIN_PULSE) : 1;
  localparam int CGW = (COIN_GAP   > 1) ? $clog2(COIN_GAP)   : 1;
  localparam int CW  = (CPW > CGW) ? CPW : CGW;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } coin_state_e;

  // ---------------------------------------------------------------------
  // Stage 0: input register and previous coin level for edge detection
  // ---------------------------------------------------------------------
  logic [NPLAYERS*JW-1:0] in_q;
  logic [NPLAYERS-1:0]    coin_p_q, coin_p_d;
  logic                   primed_q;
  logic [NPLAYERS-1:0]    rise;

  // On the first edge after reset the previous-level register loads the
  // live input, so a coin held through reset does not look like a press.
  always_comb begin
    coin_p_d = '0;
    for (int unsigned p = 0; p < NPLAYERS; p++) begin
      coin_p_d[p] = primed_q ? in_q[p*JW + COIN_BIT] : joy_in[p*JW + COIN_BIT];
      rise[p]     = in_q[p*JW + COIN_BIT] & ~coin_p_q[p];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      in_q     <= '0;
      coin_p_q <= '0;
      primed_q <= 1'b0;
    end else begin
      in_q     <= joy_in;
      coin_p_q <= coin_p_d;
      primed_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Autofire timebase (free running, shared by all players)
  // ---------------------------------------------------------------------
  logic [AFW-1:0] af_cnt_q, af_cnt_d;
  logic           af_phase_q, af_phase_d;
  logic           af_wrap;

  always_comb begin
    af_wrap    = (af_cnt_q == AFW'(AF_PERIOD - 1));
    af_cnt_d   = af_wrap ? '0 : af_cnt_q + 1'b1;
    af_phase_d = af_phase_q ^ af_wrap;
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      af_cnt_q   <= '0;
      af_phase_q <= 1'b1;
    end else begin
      af_cnt_q   <= af_cnt_d;
      af_phase_q <= af_phase_d;
    end
  end

  // ---------------------------------------------------------------------
  // Per-player processing and routing
  // ---------------------------------------------------------------------
  logic [JW-1:0]          proc_w [NPLAYERS];
  logic [JW-1:0]          merged;
  logic [NPLAYERS*JW-1:0] joy_d;

  always_comb begin
    merged = '0;
    joy_d  = '0;
    for (int unsigned p = 0; p < NPLAYERS; p++) begin
      proc_w[p] = in_q[p*JW +: JW];
      if (af_en && !af_phase_q) proc_w[p] = proc_w[p] & ~af_mask;
      proc_w[p][COIN_BIT] = 1'b0;
`ifdef ARCADE_INPUT_SOCD_EN
      if (proc_w[p][3] && proc_w[p][2]) proc_w[p][3:2] = 2'b00;
      if (proc_w[p][1] && proc_w[p][0]) proc_w[p][1:0] = 2'b00;
`endif
      merged = merged | proc_w[p];
    end
    for (int unsigned p = 0; p < NPLAYERS; p++) begin
      joy_d[p*JW +: JW] = share ? merged : proc_w[p];
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) joy_out <= '0;
    else       joy_out <= joy_d;
  end

  // ---------------------------------------------------------------------
  // Coin FSM per player
  // ---------------------------------------------------------------------
  coin_state_e     state_q [NPLAYERS];
  coin_state_e     state_d [NPLAYERS];
  logic [1:0]      pend_q  [NPLAYERS];
  logic [1:0]      pend_d  [NPLAYERS];
  logic [CW-1:0]   cnt_q   [NPLAYERS];
  logic [CW-1:0]   cnt_d   [NPLAYERS];
  logic [NPLAYERS-1:0] start_c;

  always_ff @(posedge clk_sys) begin
    for (int unsigned p = 0; p < NPLAYERS; p++) begin
      if (reset) begin
        state_q[p] <= IDLE;
        pend_q[p]  <= '0;
        cnt_q[p]   <= '0;
      end else begin
        state_q[p] <= state_d[p];
        pend_q[p]  <= pend_d[p];
        cnt_q[p]   <= cnt_d[p];
      end
    end
  end

  always_comb begin
    start_c = '0;
    for (int unsigned p = 0; p < NPLAYERS; p++) begin
      state_d[p] = state_q[p];
      cnt_d[p]   = cnt_q[p];
      unique case (state_q[p])
        IDLE: begin
          if (pend_q[p] != 2'd0) begin
            state_d[p] = PULSE;
            cnt_d[p]   = '0;
            start_c[p] = 1'b1;
          end
        end
        PULSE: begin
          if (cnt_q[p] == CW'(COIN_PULSE - 1)) begin
            state_d[p] = GAP;
            cnt_d[p]   = '0;
          end else begin
            cnt_d[p] = cnt_q[p] + 1'b1;
          end
        end
        GAP: begin
          if (cnt_q[p] == CW'(COIN_GAP - 1)) begin
            cnt_d[p] = '0;
            if (pend_q[p] != 2'd0) begin
              state_d[p] = PULSE;
              start_c[p] = 1'b1;
            end else begin
              state_d[p] = IDLE;
            end
          end else begin
            cnt_d[p] = cnt_q[p] + 1'b1;
          end
        end
        default: begin
          state_d[p] = IDLE;
          cnt_d[p]   = '0;
        end
      endcase

      // Simultaneous press and credit start cancel; saturation only
      // matters when nothing is consumed this cycle.
      pend_d[p] = pend_q[p];
      if (rise[p] && start_c[p])        pend_d[p] = pend_q[p];
      else if (start_c[p])              pend_d[p] = pend_q[p] - 2'd1;
      else if (rise[p] && pend_q[p] != 2'd3) pend_d[p] = pend_q[p] + 2'd1;
    end
  end

  always_comb begin
    coin_out  = '0;
    coin_busy = '0;
    for (int unsigned p = 0; p < NPLAYERS; p++) begin
      coin_out[p]  = (state_q[p] == PULSE);
      coin_busy[p] = (state_q[p] != IDLE) || (pend_q[p] != 2'd0);
    end
  end

endmodule

// File: tb/tb_arcade_input_cond.sv
module tb_arcade_input_cond;

  localparam int NP  = 2;
  localparam int JW  = 16;
  localparam int CB  = 8;
  localparam int CP  = 4;
  localparam int CG  = 3;
  localparam int AFP = 2;

  logic              clk_sys = 1'b0;
  logic              reset;
  logic [NP*JW-1:0]  joy_in;
  logic              share;
  logic              af_en;
  logic [JW-1:0]     af_mask;
  logic [NP*JW-1:0]  joy_out;
  logic [NP-1:0]     coin_out;
  logic [NP-1:0]     coin_busy;

  arcade_input_cond #(
    .NPLAYERS  (NP),
    .JW        (JW),
    .COIN_BIT  (CB),
    .COIN_PULSE(CP),
    .COIN_GAP  (CG),
    .AF_PERIOD (AFP)
  ) dut (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .joy_in   (joy_in),
    .share    (share),
    .af_en    (af_en),
    .af_mask  (af_mask),
    .joy_out  (joy_out),
    .coin_out (coin_out),
    .coin_busy(coin_busy)
  );

  always #5 clk_sys = ~clk_sys;

  int errors = 0;
  int checks = 0;

  // Reference model: coin activity as a single countdown of remaining
  // busy cycles (pulse then gap), credits as a plain integer.
  logic [NP*JW-1:0] m_inr;
  logic [NP-1:0]    m_inp;
  bit               m_primed;
  logic [NP*JW-1:0] m_jout;
  int               m_rem  [NP];
  int               m_pend [NP];
  int               m_c;

  function automatic logic [NP*JW-1:0] model_joy(input logic [NP*JW-1:0] inr,
                                                 input logic ph, input logic sh,
                                                 input logic en, input logic [JW-1:0] mask);
    logic [JW-1:0]    w [NP];
    logic [JW-1:0]    orw;
    logic [NP*JW-1:0] r;
    orw = '0;
    r   = '0;
    for (int p = 0; p < NP; p++) begin
      w[p] = inr[p*JW +: JW];
      if (en && !ph) w[p] = w[p] & ~mask;
      w[p][CB] = 1'b0;
`ifdef ARCADE_INPUT_SOCD_EN
      if (w[p][3] && w[p][2]) w[p][3:2] = 2'b00;
      if (w[p][1] && w[p][0]) w[p][1:0] = 2'b00;
`endif
      orw = orw | w[p];
    end
    for (int p = 0; p < NP; p++) r[p*JW +: JW] = sh ? orw : w[p];
    return r;
  endfunction

  task automatic model_edge();
    logic ph;
    bit   rise, dec;
    if (reset) begin
      m_inr = '0; m_inp = '0; m_primed = 0; m_jout = '0; m_c = 0;
      for (int p = 0; p < NP; p++) begin m_rem[p] = 0; m_pend[p] = 0; end
    end else begin
      ph = (((m_c / AFP) % 2) == 0);
      for (int p = 0; p < NP; p++) begin
        rise = m_inr[p*JW+CB] && !m_inp[p];
        dec  = (m_rem[p] <= 1) && (m_pend[p] > 0);
        if (dec && !rise)                 m_pend[p]--;
        else if (rise && !dec && m_pend[p] < 3) m_pend[p]++;
        if (dec)               m_rem[p] = CP + CG;
        else if (m_rem[p] > 0) m_rem[p]--;
      end
      m_jout = model_joy(m_inr, ph, share, af_en, af_mask);
      for (int p = 0; p < NP; p++)
        m_inp[p] = m_primed ? m_inr[p*JW+CB] : joy_in[p*JW+CB];
      m_inr = joy_in;
      m_primed = 1;
      m_c++;
    end
  endtask

  function automatic logic [NP-1:0] exp_coin();
    logic [NP-1:0] r;
    for (int p = 0; p < NP; p++) r[p] = (m_rem[p] > CG);
    return r;
  endfunction

  function automatic logic [NP-1:0] exp_busy();
    logic [NP-1:0] r;
    for (int p = 0; p < NP; p++) r[p] = (m_rem[p] > 0) || (m_pend[p] > 0);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".joy_out"},   joy_out,   m_jout);
    check({tag, ".coin_out"},  coin_out,  exp_coin());
    check({tag, ".coin_busy"}, coin_busy, exp_busy());
  endtask

  task automatic tick();
    @(posedge clk_sys);
    model_edge();
    @(negedge clk_sys);
  endtask

  task automatic set_coin0(input logic v);
    joy_in[CB] = v;
  endtask

  int   hi_cnt, rises, p1_hi, b8_hi, waited;
  logic prev;
  logic [JW-1:0] w0, w1;

  initial begin
    reset = 1'b1; joy_in = '1; share = 1'b0; af_en = 1'b0; af_mask = '0;
    @(negedge clk_sys);

    // Reset with all inputs high
    tick(); tick();
    check_all("reset");
    check("rst_joy", joy_out, 0);
    check("rst_coin", coin_out, 0);
    check("rst_busy", coin_busy, 0);

    // Coin held through reset release must not credit
    reset = 1'b0;
    repeat (6) begin tick(); check_all("held"); end
    check("held_no_credit", coin_busy, 0);

    // Routing
    joy_in = {16'h0001, 16'h0010}; share = 1'b1;
    tick(); check_all("share1");
    tick(); check_all("share2");
    check("share_or", joy_out, 32'h0011_0011);
    share = 1'b0;
    tick(); check_all("split");
    check("split_val", joy_out, 32'h0001_0010);

    // Coin queue: three single-cycle presses two cycles apart
    joy_in = '0;
    tick(); tick(); check_all("pre_q");
    hi_cnt = 0; rises = 0; p1_hi = 0; b8_hi = 0; prev = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_coin0(1'b1); tick(); check_all("q_press");
      if (coin_out[0] && !prev) rises++;
      if (coin_out[0]) hi_cnt++;
      prev = coin_out[0];
      set_coin0(1'b0); tick(); check_all("q_rel");
      if (coin_out[0] && !prev) rises++;
      if (coin_out[0]) hi_cnt++;
      prev = coin_out[0];
    end
    waited = 0;
    while (coin_busy[0] && waited < 60) begin
      tick(); check_all("q_run");
      if (coin_out[0] && !prev) rises++;
      if (coin_out[0]) hi_cnt++;
      if (coin_out[1]) p1_hi++;
      if (joy_out[CB]) b8_hi++;
      prev = coin_out[0];
      waited++;
    end
    check("queue_idle", coin_busy, 0);
    check("queue_high_cycles", hi_cnt, 3*CP);
    check("queue_pulses", rises, 3);
    check("queue_p1_quiet", p1_hi, 0);
    check("queue_bit8", b8_hi, 0);

    // Saturation: one press, then five more while the first credit runs
    rises = 0; prev = 1'b0;
    set_coin0(1'b1); tick(); check_all("sat0");
    set_coin0(1'b0); tick(); check_all("sat0r");
    for (int i = 0; i < 5; i++) begin
      set_coin0(1'b1); tick(); check_all("sat_p");
      if (coin_out[0] && !prev) rises++;
      prev = coin_out[0];
      set_coin0(1'b0); tick(); check_all("sat_r");
      if (coin_out[0] && !prev) rises++;
      prev = coin_out[0];
    end
    waited = 0;
    while (coin_busy[0] && waited < 100) begin
      tick(); check_all("sat_run");
      if (coin_out[0] && !prev) rises++;
      prev = coin_out[0];
      waited++;
    end
    check("sat_idle", coin_busy, 0);
    check("sat_pulses", rises, 5);

    // Autofire on bit 4 only; bit 5 held steady
    joy_in = {16'h0000, 16'h0030}; af_en = 1'b1; af_mask = 16'h0010;
    tick(); check_all("af0");
    tick(); check_all("af1");
    repeat (10) begin
      tick(); check_all("af");
      check("af_bit5", joy_out[5], 1);
    end

    // Opposite directions
    af_en = 1'b0; joy_in = {16'h0000, 16'h0003};
    tick(); tick(); check_all("socd");
`ifdef ARCADE_INPUT_SOCD_EN
    check("socd_val", joy_out[15:0], 16'h0000);
`else
    check("socd_val", joy_out[15:0], 16'h0003);
`endif

    // Reset mid-pulse with a queued credit
    joy_in = '0; tick();
    set_coin0(1'b1); tick(); set_coin0(1'b0); tick();
    set_coin0(1'b1); tick(); set_coin0(1'b0);
    waited = 0;
    while (!coin_out[0] && waited < 20) begin tick(); waited++; end
    check("mid_pulse_reached", coin_out[0], 1);
    check_all("mid_pulse");
    reset = 1'b1; tick();
    check_all("rst_mid");
    check("rst_mid_coin", coin_out, 0);
    reset = 1'b0;
    repeat (12) begin tick(); check_all("post_rst"); end
    check("post_rst_lost", coin_busy, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      w0 = JW'($urandom); w1 = JW'($urandom);
      w0[CB] = ($urandom_range(0, 3) == 0);
      w1[CB] = ($urandom_range(0, 3) == 0);
      joy_in = {w1, w0};
      if ($urandom_range(0, 7) == 0) share = ~share;
      if ($urandom_range(0, 7) == 0) af_en = ~af_en;
      if ($urandom_range(0, 15) == 0) af_mask = JW'($urandom);
      reset = ($urandom_range(0, 99) == 0);
      tick(); check_all("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
